// File: rtl/chunked_addsub_if.sv
// Operand/result bundle for chunked_addsub: start/busy/done handshake, no backpressure;
// a new start is only honoured by the slave when it is not busy.
interface chunked_addsub_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_addsub.sv
// Sequential WIDTH-bit add/sub, CHUNK bits per cycle: N=WIDTH/CHUNK busy cycles, then a one-cycle done.
// No backpressure: start is ignored while busy; results hold until the next done.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  chunked_addsub_if.slave io
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_d, sum_q;
  logic             carry_q, cout_q, ovf_q;
  logic [IDXW-1:0]  idx_q;
  logic [CHUNK-1:0] chunk_sum;
  logic [CHUNK:0]   cy;
  logic             accept, last;

  assign accept = io.start && ((state_q == IDLE) || (state_q == DONE));
  assign last   = (idx_q == IDXW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands shift down each cycle so the active chunk always sits in the low CHUNK bits.
  always_comb begin
    cy        = '0;
    chunk_sum = '0;
    cy[0]     = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_sum[i] = a_q[i] ^ b_q[i] ^ cy[i];
      cy[i+1]      = (a_q[i] & b_q[i]) | (cy[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // Finished chunks enter at the top, so after N cycles chunk 0 lands at bit 0.
  assign res_d = (res_q >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= io.a;
      b_q     <= io.sub ? ~io.b : io.b;
      carry_q <= io.cin ^ io.sub;
      res_q   <= '0;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      res_q   <= res_d;
      carry_q <= cy[CHUNK];
      idx_q   <= idx_q + 1'b1;
      if (last) begin
        sum_q  <= res_d;
        cout_q <= cy[CHUNK];
        ovf_q  <= cy[CHUNK-1] ^ cy[CHUNK];
      end
    end
  end

  assign io.busy = (state_q == RUN);
  assign io.done = (state_q == DONE);
  assign io.sum  = sum_q;
  assign io.cout = cout_q;
  assign io.ovf  = ovf_q;
endmodule
